// File: rtl/vga_timing_out.sv
// VGA raster timing generator and DAC output stage; sync/blank are delayed PIX_LAT+1 clocks from x_pos/y_pos.
// Optional VGA_TESTPAT_EN replaces pixel_data with eight internal colour bars.
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIX_LAT  = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    input  logic [11:0] pixel_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
        end else begin
            x_pos       <= h_cnt;
            y_pos       <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Raw timing is taken from x_pos/y_pos, the same position the page is rendering.
    logic active_raw;
    logic hs_raw;
    logic vs_raw;

    assign active_raw = (x_pos < 10'(H_ACTIVE)) && (y_pos < 10'(V_ACTIVE));
    assign hs_raw     = (x_pos >= 10'(HS_START)) && (x_pos < 10'(HS_END));
    assign vs_raw     = (y_pos >= 10'(VS_START)) && (y_pos < 10'(VS_END));

    logic [PIX_LAT-1:0] active_pipe;
    logic [PIX_LAT-1:0] hs_pipe;
    logic [PIX_LAT-1:0] vs_pipe;

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            active_pipe <= '0;
            hs_pipe     <= '0;
            vs_pipe     <= '0;
        end else begin
            active_pipe[0] <= active_raw;
            hs_pipe[0]     <= hs_raw;
            vs_pipe[0]     <= vs_raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                active_pipe[i] <= active_pipe[i-1];
                hs_pipe[i]     <= hs_pipe[i-1];
                vs_pipe[i]     <= vs_pipe[i-1];
            end
        end
    end

    logic        active_d;
    logic        hs_d;
    logic        vs_d;
    logic [11:0] pix_sel;

    assign active_d = active_pipe[PIX_LAT-1];
    assign hs_d     = hs_pipe[PIX_LAT-1];
    assign vs_d     = vs_pipe[PIX_LAT-1];

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_raw;
    logic [2:0] bar_pipe [PIX_LAT];
    logic [2:0] bar_d;

    assign bar_raw = 3'(x_pos / 10'(BAR_W));
    assign bar_d   = bar_pipe[PIX_LAT-1];

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            for (int i = 0; i < PIX_LAT; i++) bar_pipe[i] <= '0;
        end else begin
            bar_pipe[0] <= bar_raw;
            for (int i = 1; i < PIX_LAT; i++) bar_pipe[i] <= bar_pipe[i-1];
        end
    end

    // Bar order fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000 reduces to one index bit per channel.
    assign pix_sel = {{4{~bar_d[0]}}, {4{~bar_d[2]}}, {4{~bar_d[1]}}};
`else
    assign pix_sel = pixel_data;
`endif

    always_ff @(posedge vga_clk or posedge vga_rst) begin
        if (vga_rst) begin
            vga_hs <= ~SYNC_ON;
            vga_vs <= ~SYNC_ON;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= hs_d ? SYNC_ON : ~SYNC_ON;
            vga_vs <= vs_d ? SYNC_ON : ~SYNC_ON;
            vga_r  <= active_d ? pix_sel[3:0]  : 4'h0;
            vga_g  <= active_d ? pix_sel[7:4]  : 4'h0;
            vga_b  <= active_d ? pix_sel[11:8] : 4'h0;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: random pixel data against a position-arithmetic raster model.
// Vertical timing is shortened so full frames fit in a short run; horizontal timing is the 640x480 default.
module tb_vga_timing_out;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 20;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 4;
    localparam int PL       = 1;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = HT * VT;
    localparam logic [11:0] BARS [8] = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0,
                                         12'hf0f, 12'hf00, 12'h00f, 12'h000};

    logic        vga_clk;
    logic        vga_rst;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        frame_start;
    logic [11:0] pixel_data;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    vga_timing_out #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(0), .PIX_LAT(PL)
    ) dut (
        .vga_clk(vga_clk), .vga_rst(vga_rst),
        .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
        .pixel_data(pixel_data),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          k;
    int          edge_abs = 0;
    int          hs_run;
    int          vs_run;
    int          last_fs;
    bit          first_fall_seen;
    bit          fff_mode = 1'b0;
    logic [11:0] pd_cur;

    function automatic int px(input int p);
        return p % HT;
    endfunction

    function automatic int py(input int p);
        return (p / HT) % VT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(x_pos), 0);
        check({tag, "_y"}, 32'(y_pos), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_hs"}, 32'(vga_hs), 1);
        check({tag, "_vs"}, 32'(vga_vs), 1);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
    endtask

    // k = clock edges since reset release; x_pos after edge j shows raster position max(j-1,0),
    // and the pins after edge k show the position x_pos held PL+1 edges earlier.
    task automatic check_cycle();
        int pc, pp, x, y, er, eg, eb, ehs, evs;
        logic [11:0] col;
        pc = (k == 0) ? 0 : k - 1;
        check("x_pos", 32'(x_pos), px(pc));
        check("y_pos", 32'(y_pos), py(pc));
        check("frame_start", 32'(frame_start), (k >= 1 && pc % FRAME == 0) ? 1 : 0);
        ehs = 1; evs = 1; er = 0; eg = 0; eb = 0;
        if (k >= PL + 1) begin
            pp = (k - 2 - PL < 0) ? 0 : k - 2 - PL;
            x = px(pp);
            y = py(pp);
            if (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ehs = 0;
            if (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) evs = 0;
            if (x < H_ACTIVE && y < V_ACTIVE) begin
`ifdef VGA_TESTPAT_EN
                col = BARS[x / (H_ACTIVE / 8)];
                er = int'(col[11:8]); eg = int'(col[7:4]); eb = int'(col[3:0]);
`else
                col = pd_cur;
                er = int'(col[3:0]); eg = int'(col[7:4]); eb = int'(col[11:8]);
`endif
            end
            if (x == 100 && y == 10) check("px_100_10_g", 32'(vga_g), 15);
        end
        check("vga_hs", 32'(vga_hs), ehs);
        check("vga_vs", 32'(vga_vs), evs);
        check("vga_r", 32'(vga_r), er);
        check("vga_g", 32'(vga_g), eg);
        check("vga_b", 32'(vga_b), eb);

        if (vga_hs === 1'b0) begin
            if (hs_run == 0 && !first_fall_seen) begin
                check("hs_first_fall", k, 658 + PL);
                first_fall_seen = 1'b1;
            end
            hs_run++;
        end else if (hs_run > 0) begin
            check("hs_width", hs_run, H_SYNC);
            hs_run = 0;
        end
        if (vga_vs === 1'b0) vs_run++;
        else if (vs_run > 0) begin
            check("vs_width", vs_run, V_SYNC * HT);
            vs_run = 0;
        end
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("fs_period", edge_abs - last_fs, FRAME);
            last_fs = edge_abs;
        end
    endtask

    task automatic drive_next();
        int pn;
        logic [11:0] d;
        pn = k - 1 - PL;
        if (fff_mode) d = 12'hfff;
        else if (pn >= 0 && px(pn) == 100 && py(pn) == 10) d = 12'h0f0;
        else d = 12'($urandom);
        pd_cur     = d;
        pixel_data = d;
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
        k++;
        edge_abs++;
        check_cycle();
        drive_next();
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        vga_rst = 1'b0;
        k = 0;
        hs_run = 0;
        vs_run = 0;
        last_fs = -1;
        first_fall_seen = 1'b0;
        check_cycle();
        drive_next();
    endtask

    initial begin
        vga_rst    = 1'b1;
        pixel_data = '0;
        pd_cur     = '0;
        k          = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_values("rst_hold");
        release_reset();

        repeat (FRAME + 2 * HT) step();

        for (int n = 0; n < FRAME && !(k >= 1 && px(k - 1) == 300 && py(k - 1) == 10); n++) step();
        check("mid_reset_pos_x", 32'(x_pos), 300);
        vga_rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_values("rst_mid_hold");
        fff_mode = 1'b1;
        release_reset();

        repeat (FRAME + HT) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
